// File: rtl/cpu6_dmem.sv
// cpu6_dmem: data-side memory responder for the cpu6 core.
// Word RAM (not cleared by reset) plus an MMIO window holding the tohost
// mailbox, a status word and, when CPU6_DMEM_TIMER_EN is defined, the
// 64-bit mtime/mtimecmp timer with its interrupt.
module cpu6_dmem #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [15:0] MMIO_PAGE = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwriteE,
    input  logic [31:0] dataaddr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tohost_valid,
    output logic [31:0] tohost_data,
    output logic        timer_irq,
    output logic        misalign_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [15:0] OFF_TOHOST  = 16'h0000;
    localparam logic [15:0] OFF_MTIMELO = 16'h0004;
    localparam logic [15:0] OFF_MTIMEHI = 16'h0008;
    localparam logic [15:0] OFF_CMPLO   = 16'h000C;
    localparam logic [15:0] OFF_CMPHI   = 16'h0010;
    localparam logic [15:0] OFF_STATUS  = 16'h0014;

    logic [31:0]   mem_q [DEPTH];
    logic          tohost_valid_q;
    logic [31:0]   tohost_data_q;
    logic          misalign_q;

    logic          is_mmio;
    logic          aligned;
    logic          st_ok;
    logic [AW-1:0] ram_idx;
    logic [15:0]   off_w;

    assign is_mmio = (dataaddr[31:16] == MMIO_PAGE);
    assign aligned = (dataaddr[1:0] == 2'b00);
    assign st_ok   = memwriteE && aligned;
    assign ram_idx = dataaddr[AW+1:2];
    assign off_w   = {dataaddr[15:2], 2'b00};

    // RAM store port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (!reset && st_ok && !is_mmio) begin
            mem_q[ram_idx] <= writedata;
        end
    end

    // Mailbox and sticky misalignment flag
    always_ff @(posedge clk) begin
        if (reset) begin
            tohost_valid_q <= 1'b0;
            tohost_data_q  <= '0;
            misalign_q     <= 1'b0;
        end else begin
            tohost_valid_q <= st_ok && is_mmio && (off_w == OFF_TOHOST);
            if (st_ok && is_mmio && (off_w == OFF_TOHOST)) begin
                tohost_data_q <= writedata;
            end
            if (memwriteE && !aligned) begin
                misalign_q <= 1'b1;
            end
        end
    end

`ifdef CPU6_DMEM_TIMER_EN
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtime_inc;
    logic        irq_q;

    assign mtime_inc = mtime_q + 64'd1;

    // mtime next state: a LO store replaces the low word with no increment or
    // carry; a HI store keeps the low-word increment but drops its carry
    always_comb begin
        mtime_d = mtime_inc;
        if (st_ok && is_mmio && (off_w == OFF_MTIMELO)) begin
            mtime_d = {mtime_q[63:32], writedata};
        end else if (st_ok && is_mmio && (off_w == OFF_MTIMEHI)) begin
            mtime_d = {writedata, mtime_inc[31:0]};
        end
    end

    // Timer registers; irq compares the pre-update values
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            irq_q   <= (mtime_q >= mtimecmp_q);
            if (st_ok && is_mmio && (off_w == OFF_CMPLO)) begin
                mtimecmp_q[31:0] <= writedata;
            end
            if (st_ok && is_mmio && (off_w == OFF_CMPHI)) begin
                mtimecmp_q[63:32] <= writedata;
            end
        end
    end

    assign timer_irq = irq_q;
`else
    assign timer_irq = 1'b0;
`endif

    // Combinational load path; low address bits ignored
    always_comb begin
        readdata = '0;
        if (is_mmio) begin
            case (off_w)
                OFF_TOHOST:  readdata = tohost_data_q;
                OFF_STATUS:  readdata = {31'b0, misalign_q};
`ifdef CPU6_DMEM_TIMER_EN
                OFF_MTIMELO: readdata = mtime_q[31:0];
                OFF_MTIMEHI: readdata = mtime_q[63:32];
                OFF_CMPLO:   readdata = mtimecmp_q[31:0];
                OFF_CMPHI:   readdata = mtimecmp_q[63:32];
`endif
                default:     readdata = '0;
            endcase
        end else begin
            readdata = mem_q[ram_idx];
        end
    end

    assign tohost_valid = tohost_valid_q;
    assign tohost_data  = tohost_data_q;
    assign misalign_err = misalign_q;

endmodule
